// File: rtl/hand_pkg.sv
// Shared helpers for the round-robin arbiter: index width function and source index type.
// Latency: none (types and elaboration-time constants only).
// Backpressure: not applicable.
package hand_pkg;

   // Widest source index the arbiter supports (N up to 16)
   localparam int SRC_W_MAX = 4;

   typedef logic [SRC_W_MAX-1:0] src_idx_t;

   // clog2 with a floor of 1 so a 2-requester arbiter still gets a 1-bit index
   function automatic int idx_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its load enable.
module rr_pick
   import hand_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx
);

   // Two copies back to back let a straight scan from ptr cover the wrap
   logic [2*N-1:0] req_dbl;

   assign req_dbl = {req, req};

   // Scan downward so the lowest offset from ptr is the one left standing
   always_comb begin
      logic [IW:0] pos;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      pos       = '0;
      for (int j = N - 1; j >= 0; j--) begin
         pos = {1'b0, ptr} + (IW+1)'(j);
         if (req_dbl[pos]) begin
            gnt_valid = 1'b1;
            gnt_idx   = (pos >= (IW+1)'(N)) ? IW'(pos - (IW+1)'(N)) : pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/hand_rr_arbiter.sv
// N-to-1 round-robin arbiter with a registered output slot; HAND_RR_ARBITER_HOLD_EN enables grant hold.
// Latency: 1 cycle from upstream accept to m_valid; 1 beat/cycle with m_ready high.
// Backpressure: when the slot is full and m_ready is low, all s_ready drop and ptr freezes.
module hand_rr_arbiter
   import hand_pkg::*;
#(
   parameter  int L    = 8,
   parameter  int N    = 4,
   parameter  int HOLD = 4,
   localparam int IW   = idx_w(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   s_valid,
   input  logic [N*L-1:0] s_data,
   output logic [N-1:0]   s_ready,
   output logic           m_valid,
   output logic [L-1:0]   m_data,
   output logic [IW-1:0]  m_src,
   input  logic           m_ready
);

   logic          load;
   logic          xfer;
   logic          gnt_valid;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] nxt_idx;
   logic [IW-1:0] ptr;
   logic [L-1:0]  sel_data;

   // Slot can take a new beat when empty or draining this cycle
   assign load = !m_valid || m_ready;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req       (s_valid),
      .ptr       (ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Decode the grant into a one-hot ready and select the granted data lane
   always_comb begin
      s_ready  = '0;
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_data   = s_data[i*L +: L];
            s_ready[i] = rst && load && gnt_valid && s_valid[i];
         end
      end
   end

   assign xfer    = |s_ready;
   assign nxt_idx = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

   // Output slot: load on accept, empty when nothing is accepted, hold when stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_src   <= '0;
      end else if (load) begin
         m_valid <= xfer;
         if (xfer) begin
            m_data <= sel_data;
            m_src  <= gnt_idx;
         end
      end
   end

`ifdef HAND_RR_ARBITER_HOLD_EN
   localparam int HW = idx_w(HOLD + 1);

   logic [HW-1:0] hcnt;
   logic [HW-1:0] run;
   logic          ptr_vld;
   logic [IW-1:0] ptr_nxt;

   // Is the requester currently holding the pointer still asking?
   always_comb begin
      ptr_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (ptr == IW'(i)) ptr_vld = s_valid[i];
      end
   end

   // Beats in the current run including this one; a new owner starts at 1
   assign run     = (gnt_idx == ptr) ? hcnt + 1'b1 : HW'(1);
   assign ptr_nxt = (ptr == IW'(N - 1)) ? '0 : ptr + 1'b1;

   // Keep ptr on the owner until its run reaches HOLD beats or it drops valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr  <= '0;
         hcnt <= '0;
      end else if (xfer) begin
         if (run >= HW'(HOLD)) begin
            ptr  <= nxt_idx;
            hcnt <= '0;
         end else begin
            ptr  <= gnt_idx;
            hcnt <= run;
         end
      end else if ((hcnt != '0) && !ptr_vld) begin
         ptr  <= ptr_nxt;
         hcnt <= '0;
      end
   end
`else
   // HOLD only sizes the hold counter; this empty guard keeps it referenced in both builds
   if (HOLD < 1) begin : g_hold_range
   end

   // Plain round robin: step past whoever was just served
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= nxt_idx;
      end
   end
`endif

endmodule

// File: tb/tb_hand_rr_arbiter.sv
// Randomised scoreboard bench for hand_rr_arbiter against a queue-based reference model.
// Latency: model expects each accepted beat on m_data one cycle after acceptance.
// Backpressure: random m_ready; model tracks slot occupancy to predict s_ready.
module tb_hand_rr_arbiter;

   localparam int L    = 8;
   localparam int N    = 4;
   localparam int HOLD = 4;
   localparam int IW   = 2;

   logic           clk     = 1'b0;
   logic           rst     = 1'b1;
   logic [N-1:0]   s_valid = '0;
   logic [N*L-1:0] s_data  = '0;
   logic [N-1:0]   s_ready;
   logic           m_valid;
   logic [L-1:0]   m_data;
   logic [IW-1:0]  m_src;
   logic           m_ready = 1'b0;

   typedef struct {
      int src;
      int data;
   } beat_t;

   beat_t exp_q[$];

   int total = 0;
   int bad   = 0;

   // reference model state
   int         mptr     = 0;
   int         hold_src = -1;
   int         hold_run = 0;
   bit         slot     = 1'b0;
   logic [N-1:0] acc    = '0;

   // stimulus controls
   int           stim_mode = 0;
   logic [N-1:0] req_mask  = '0;
   int           req_pct   = 0;
   int           rdy_pct   = 100;

   hand_rr_arbiter #(
      .L    (L),
      .N    (N),
      .HOLD (HOLD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_src   (m_src),
      .m_ready (m_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // Stimulus: valid is held with stable data until the model says it was accepted
   initial forever begin
      @(posedge clk);
      #1;
      if (stim_mode == 0) begin
         s_valid = '1;
         s_data  = {$urandom, $urandom};
         m_ready = 1'b0;
      end else if (!rst) begin
         s_valid = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (acc[i]) s_valid[i] = 1'b0;
            if (!s_valid[i] && req_mask[i] && (int'($urandom_range(99)) < req_pct)) begin
               s_valid[i]       = 1'b1;
               s_data[i*L +: L] = 8'($urandom);
            end
         end
         m_ready = int'($urandom_range(99)) < rdy_pct;
      end
   end

   // Reference model: grant = first valid requester scanning from the model pointer
   initial forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
         chk("s_ready_in_reset", int'(s_ready), 0);
         slot     = 1'b0;
         mptr     = 0;
         hold_src = -1;
         hold_run = 0;
         acc      = '0;
         exp_q.delete();
      end else begin
         bit load;
         bit found;
         int g;
         int exp_rdy;
         load  = !slot || m_ready;
         found = 1'b0;
         g     = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && s_valid[(mptr + k) % N]) begin
               found = 1'b1;
               g     = (mptr + k) % N;
            end
         end
         exp_rdy = (load && found) ? (1 << g) : 0;
         chk("s_ready", int'(s_ready), exp_rdy);
         acc = exp_rdy[N-1:0];
         if (load) slot = found;
         if (load && found) begin
            exp_q.push_back('{g, int'(s_data[g*L +: L])});
`ifdef HAND_RR_ARBITER_HOLD_EN
            if (g == hold_src) begin
               hold_run++;
            end else begin
               hold_src = g;
               hold_run = 1;
            end
            if (hold_run >= HOLD) begin
               mptr     = (g + 1) % N;
               hold_src = -1;
               hold_run = 0;
            end else begin
               mptr = g;
            end
`else
            mptr = (g + 1) % N;
`endif
         end
`ifdef HAND_RR_ARBITER_HOLD_EN
         else if (hold_src >= 0 && !s_valid[hold_src]) begin
            mptr     = (hold_src + 1) % N;
            hold_src = -1;
            hold_run = 0;
         end
`endif
      end
   end

   // Monitor: compare whatever sits in the output slot against the oldest expected beat
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("m_valid_in_reset", int'(m_valid), 0);
      end else if (exp_q.size() == 0) begin
         chk("m_valid_idle", int'(m_valid), 0);
      end else begin
         chk("m_valid", int'(m_valid), 1);
         chk("m_src", int'(m_src), exp_q[0].src);
         chk("m_data", int'(m_data), exp_q[0].data);
         if (m_ready) void'(exp_q.pop_front());
      end
   end

   task automatic phase(input logic [N-1:0] mask, input int rpct, input int mpct, input int cycles);
      req_mask = mask;
      req_pct  = rpct;
      rdy_pct  = mpct;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      bit stalled;
      bit seen;
      #1;
      rst = 1'b0;
      // reset with every requester asking
      repeat (3) begin
         @(negedge clk);
         #2;
         chk("reset_m_data", int'(m_data), 0);
         chk("reset_m_src", int'(m_src), 0);
         chk("reset_s_ready", int'(s_ready), 0);
      end
      stim_mode = 1;
      req_mask  = '0;
      rdy_pct   = 100;
      @(posedge clk);
      #2;
      rst = 1'b1;
      phase(4'b0000, 0, 100, 4);     // idle
      phase(4'b0100, 100, 100, 6);   // single requester stream
      phase(4'b0000, 0, 100, 3);
      phase(4'b1111, 100, 100, 16);  // fair rotation
      phase(4'b0000, 0, 100, 3);
      phase(4'b1001, 100, 0, 5);     // stall with 3 and 0 pending
      phase(4'b1001, 100, 100, 8);
      phase(4'b0110, 100, 100, 20);  // two continuous requesters
      phase(4'b1111, 50, 70, 1500);  // random traffic

      // asynchronous reset while the slot is stalled
      req_mask = 4'b1111;
      req_pct  = 100;
      rdy_pct  = 20;
      stalled  = 1'b0;
      for (int c = 0; c < 300 && !stalled; c++) begin
         @(negedge clk);
         #2;
         if (rst && m_valid && !m_ready) stalled = 1'b1;
      end
      chk("stall_found", int'(stalled), 1);
      rst = 1'b0;
      #1;
      chk("async_m_valid", int'(m_valid), 0);
      chk("async_s_ready", int'(s_ready), 0);
      req_mask = 4'b1001;
      rdy_pct  = 100;
      repeat (2) @(negedge clk);
      #2;
      rst  = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         #2;
         if (m_valid) begin
            seen = 1'b1;
            chk("post_reset_first_src", int'(m_src), 0);
         end
      end
      chk("post_reset_beat_seen", int'(seen), 1);

      phase(4'b1111, 60, 50, 800);   // more random traffic
      phase(4'b0000, 0, 100, 8);     // drain
      chk("drain_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hand_rr_arbiter.md
Name: hand_rr_arbiter

Overview:
- Shares one downstream valid/ready channel among N upstream masters using round-robin arbitration.
- Has a registered output slot, so its timing matches the existing forward pipe stage.
- Sits between several master instances and a single forward/backward pipe or slave instance.
- Data passes through unchanged; the source index is exported alongside each beat.

Parameters:
- L, 8, data width per channel.
- N, 4, number of requesters (2..16).
- HOLD, 4, maximum consecutive beats one requester may keep the grant (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- s_valid  input  N  per-requester valid.
- s_data  input  N*L  per-requester data; requester i occupies bits [i*L +: L].
- s_ready  output  N  per-requester ready; one-hot or zero.
- m_valid  output  1  downstream valid (registered).
- m_data  output  L  downstream data (registered).
- m_src  output  clog2(N) (minimum 1)  index of the requester that produced the current m_data (registered).
- m_ready  input  1  downstream ready.

Behaviour:
- Reset, asynchronous on rst low: m_valid=0, m_data=0, m_src=0, priority pointer ptr=0, hold counter=0. s_ready is all zero while rst is low.
- Load enable: load = !m_valid || m_ready.
- Grant is combinational. It selects the first i with s_valid[i]=1, scanning ptr, ptr+1, … N-1, 0, … ptr-1 (wrap modulo N).
- s_ready[i] = load && (grant==i) && s_valid[i]. At most one bit is set. s_ready depends combinationally on m_ready and s_valid only.
- An upstream transfer occurs when s_valid[i] && s_ready[i]. On the next edge: m_data <= s_data[i], m_src <= i, m_valid <= 1.
- If load=1 and there is no upstream transfer, m_valid <= 0. If load=0, m_valid, m_data and m_src hold.
- Latency is 1 cycle. Throughput is 1 beat/cycle under continuous m_ready.
- Pointer update happens only on an upstream transfer from i: ptr <= (i+1) mod N. When i=N-1, ptr wraps to 0.
- Backpressure (m_valid=1, m_ready=0): all s_ready=0, ptr frozen, no upstream data consumed.
- Simultaneous m_ready and a new request: the drained beat and the newly loaded beat occur in the same cycle, with no bubble.
- Upstream rule: once asserted, s_valid must hold, with stable data, until accepted. The arbiter may keep presenting the same grant. Violations are not checked.
- No requests: s_ready=0. m_valid falls after draining the last beat.
- Reset mid-transfer: any in-flight beat in the output slot is dropped and ptr returns to 0.

Optional Feature:
- Macro: HAND_RR_ARBITER_HOLD_EN.
- With the macro defined: after a transfer from i, the grant stays on i (ptr not advanced) while s_valid[i] remains 1 and the hold counter is below HOLD-1. The counter increments per beat from the same i.
  - When the counter reaches HOLD-1, or i drops valid, ptr <= (i+1) mod N and the counter clears.
  - A transfer from a different requester resets the counter to 0.
- Without the macro: no hold counter exists; ptr advances after every transfer. HOLD is ignored.

Decomposition:
- Package hand_pkg: constant function for index width (clog2 with minimum 1); typedef for source index.
- Sub-module rr_pick, purely combinational: inputs req[N] and ptr; outputs gnt_valid and gnt_idx, using a double-width request vector for the wrap scan.
- hand_rr_arbiter owns the output register, ptr, the hold counter and the s_ready generation.

Test Plan:
- Reset and idle:
  - Stimulus: rst low for 3 cycles with all s_valid=1, then release with s_valid=0.
  - Required: m_valid=0, m_data=0, m_src=0, s_ready=0 throughout.
- Single requester stream:
  - Stimulus: s_valid=4'b0100, data 0x10..0x13 over 4 cycles, m_ready=1.
  - Required: m_valid from cycle 1, m_data 0x10..0x13 consecutive, m_src=2 every beat, no bubbles.
- Fair rotation:
  - Stimulus: all four requesters valid continuously, m_ready=1, feature off.
  - Required: m_src sequence 0,1,2,3,0,1,… with each requester's data in order.
- Backpressure and wrap:
  - Stimulus: requesters 3 and 0 valid, m_ready held 0 for 5 cycles, then 1.
  - Required: first beat from 3 holds on m_data with s_ready=0 during the stall; after release, the next beat is from 0 (ptr wrapped 3→0).
- Hold feature:
  - Stimulus: macro defined, HOLD=4, requesters 1 and 2 valid continuously.
  - Required: m_src = 1,1,1,1,2,2,2,2,1…
- Reset mid-operation:
  - Stimulus: assert rst while m_valid=1, m_ready=0, ptr=2.
  - Required: m_valid drops asynchronously; after release, requesters 0 and 3 both valid → requester 0 granted first.
